dma_read_engine: RTL and testbench

- Parametrised successor read-side engine for the SG DMA.
- Accepts {bytes, addr} commands from the descriptor processor into an internal command FIFO.
- Splits each command into AVMM read bursts of at most MAX_BURST beats and issues them with a proper read/waitrequest handshake.
- Issues only when the downstream data FIFO has guaranteed space. Tracks outstanding beats and reports per-command completion.

---
 rtl/dma_read_engine.sv | 224 ++++++++++++++++++++++
 tb/tb_dma_read_engine.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_read_engine.sv
// ============================================================================
//  Module   : dma_read_engine
//  Purpose  : Read-side engine for the scatter-gather DMA. Queues {bytes, addr}
//             commands, splits each one into AVMM read bursts of at most
//             MAX_BURST beats, issues a burst only when the downstream data
//             FIFO is guaranteed to have room for it, forwards the returned
//             data through one register stage and pulses cmd_done once all
//             beats of a command have come back.
//  Ports    : clk, reset_n (async, active low)
//             rd_master_*          AVMM read master (addr/read/bcount out,
//                                  wait_req/data_valid/data in)
//             dma_rd_fifo_command_req_i / bytes / addr -> command FIFO write
//             dma_rd_fifo_full_o   command FIFO full
//             dma_rd_space_i       free words in downstream data FIFO
//             dma_rd_data_o / dma_rd_data_valid_o  registered read data
//             dma_rd_cmd_done_o    one-cycle completion pulse
//             dma_rd_busy_o        command active or beats outstanding
//  Options  : `define DMA_RD_4K_BOUNDARY_EN to stop bursts crossing 4 KB
//             address boundaries.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_read_engine #(
  parameter int DATA_W    = 256,
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 16,
  parameter int BCNT_W    = 11,
  parameter int MAX_BURST = 16,
  parameter int CMD_DEPTH = 32,
  parameter int SPACE_W   = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] rd_master_addr_o,
  output logic              rd_master_read_o,
  output logic [BCNT_W-1:0] rd_master_bcount_o,
  input  logic              rd_master_wait_req_i,
  input  logic              rd_master_data_valid_i,
  input  logic [DATA_W-1:0] rd_master_data_i,
  input  logic              dma_rd_fifo_command_req_i,
  input  logic [LEN_W-1:0]  dma_rd_bytes_to_transfer_i,
  input  logic [ADDR_W-1:0] dma_rd_addr_i,
  output logic              dma_rd_fifo_full_o,
  input  logic [SPACE_W-1:0] dma_rd_space_i,
  output logic [DATA_W-1:0] dma_rd_data_o,
  output logic              dma_rd_data_valid_o,
  output logic              dma_rd_cmd_done_o,
  output logic              dma_rd_busy_o
);

  localparam int BPB    = DATA_W / 8;
  localparam int OFF_W  = $clog2(BPB);
  localparam int BEAT_W = LEN_W - OFF_W + 1;   // holds ceil(bytes/BPB)
  localparam int PTR_W  = $clog2(CMD_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int OUT_W  = SPACE_W + 1;
  localparam int CMD_W  = LEN_W + ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CALC  = 3'd2,
    S_ISSUE = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [BEAT_W-1:0] remaining;
  logic [OUT_W-1:0]  outstanding;

  // --------------------------------------------------------------------------
  // Showahead command FIFO
  // --------------------------------------------------------------------------
  logic [CMD_W-1:0]  cmd_mem [CMD_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  cmd_count;
  logic              push, pop, fifo_empty;
  logic [LEN_W-1:0]  head_bytes;
  logic [ADDR_W-1:0] head_addr;
  logic [BEAT_W-1:0] head_beats;

  assign dma_rd_fifo_full_o = (cmd_count == CNT_W'(CMD_DEPTH));
  assign fifo_empty         = (cmd_count == '0);
  assign push               = dma_rd_fifo_command_req_i & ~dma_rd_fifo_full_o;
  assign pop                = (state == S_LOAD);
  assign {head_bytes, head_addr} = cmd_mem[rd_ptr];
  assign head_beats = BEAT_W'(head_bytes[LEN_W-1:OFF_W]) + BEAT_W'(|head_bytes[OFF_W-1:0]);

  always_ff @(posedge clk) begin
    if (push) cmd_mem[wr_ptr] <= {dma_rd_bytes_to_transfer_i, dma_rd_addr_i};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cmd_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cmd_count <= cmd_count + 1'b1;
        2'b01:   cmd_count <= cmd_count - 1'b1;
        default: cmd_count <= cmd_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Burst sizing and downstream credit
  // --------------------------------------------------------------------------
  logic [BEAT_W-1:0] lim;
  logic [BCNT_W-1:0] burst;
  logic              credit_ok;
  logic              accept;
  logic [OUT_W-1:0]  out_sum, out_next;

  always_comb begin
    lim = remaining;
    if (remaining > BEAT_W'(MAX_BURST)) lim = BEAT_W'(MAX_BURST);
`ifdef DMA_RD_4K_BOUNDARY_EN
    begin : clip_4k
      logic [12:0] bnd_beats;
      // cur_addr is beat aligned, so the byte distance divides exactly.
      bnd_beats = (13'd4096 - {1'b0, cur_addr[11:0]}) >> OFF_W;
      if (32'(bnd_beats) < 32'(lim)) lim = BEAT_W'(bnd_beats);
    end
`endif
    burst = BCNT_W'(lim);
  end

  // Widened compare: space - outstanding may be negative if space shrank.
  assign credit_ok = 32'(dma_rd_space_i) >= (32'(outstanding) + 32'(burst));
  assign accept    = rd_master_read_o & ~rd_master_wait_req_i;

  // A beat returning with nothing outstanding is still forwarded, but the
  // counter must not wrap below zero.
  always_comb begin
    out_sum  = outstanding + (accept ? OUT_W'(rd_master_bcount_o) : '0);
    out_next = out_sum;
    if (rd_master_data_valid_i && (out_sum != '0)) out_next = out_sum - 1'b1;
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= S_IDLE;
      cur_addr           <= '0;
      remaining          <= '0;
      outstanding        <= '0;
      rd_master_addr_o   <= '0;
      rd_master_bcount_o <= '0;
      rd_master_read_o   <= 1'b0;
      dma_rd_cmd_done_o  <= 1'b0;
    end else begin
      outstanding       <= out_next;
      dma_rd_cmd_done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!fifo_empty) state <= S_LOAD;
        end
        S_LOAD: begin
          cur_addr  <= head_addr & ~ADDR_W'(BPB - 1);
          remaining <= head_beats;
          if (head_beats == '0) begin
            state             <= S_DONE;
            dma_rd_cmd_done_o <= 1'b1;
          end else begin
            state <= S_CALC;
          end
        end
        S_CALC: begin
          if (credit_ok) begin
            rd_master_addr_o   <= cur_addr;
            rd_master_bcount_o <= burst;
            rd_master_read_o   <= 1'b1;
            state              <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (accept) begin
            rd_master_read_o <= 1'b0;
            cur_addr         <= cur_addr + (ADDR_W'(rd_master_bcount_o) << OFF_W);
            remaining        <= remaining - BEAT_W'(rd_master_bcount_o);
            state <= (remaining == BEAT_W'(rd_master_bcount_o)) ? S_DRAIN : S_CALC;
          end
        end
        S_DRAIN: begin
          if (outstanding == '0) begin
            state             <= S_DONE;
            dma_rd_cmd_done_o <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dma_rd_busy_o = (state != S_IDLE) | (outstanding != '0);

  // --------------------------------------------------------------------------
  // Read data register stage, independent of the FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dma_rd_data_o       <= '0;
      dma_rd_data_valid_o <= 1'b0;
    end else begin
      dma_rd_data_o       <= rd_master_data_i;
      dma_rd_data_valid_o <= rd_master_data_valid_i;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dma_read_engine.sv
// ============================================================================
//  Module   : tb_dma_read_engine
//  Purpose  : Directed self-checking bench for dma_read_engine. A background
//             AVMM slave model answers accepted bursts; a monitor logs each
//             accepted burst, done pulses and forwarded beats.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_read_engine;

  localparam int DATA_W    = 256;
  localparam int ADDR_W    = 32;
  localparam int LEN_W     = 16;
  localparam int BCNT_W    = 11;
  localparam int MAX_BURST = 16;
  localparam int CMD_DEPTH = 32;
  localparam int SPACE_W   = 10;

  logic              clk;
  logic              reset_n;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_read;
  logic [BCNT_W-1:0] rd_bcount;
  logic              rd_wait_req;
  logic              rd_dv;
  logic [DATA_W-1:0] rd_data;
  logic              cmd_req;
  logic [LEN_W-1:0]  cmd_bytes;
  logic [ADDR_W-1:0] cmd_addr;
  logic              fifo_full;
  logic [SPACE_W-1:0] space;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              cmd_done;
  logic              busy;

  dma_read_engine #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .BCNT_W(BCNT_W),
    .MAX_BURST(MAX_BURST), .CMD_DEPTH(CMD_DEPTH), .SPACE_W(SPACE_W)
  ) dut (
    .clk                        (clk),
    .reset_n                    (reset_n),
    .rd_master_addr_o           (rd_addr),
    .rd_master_read_o           (rd_read),
    .rd_master_bcount_o         (rd_bcount),
    .rd_master_wait_req_i       (rd_wait_req),
    .rd_master_data_valid_i     (rd_dv),
    .rd_master_data_i           (rd_data),
    .dma_rd_fifo_command_req_i  (cmd_req),
    .dma_rd_bytes_to_transfer_i (cmd_bytes),
    .dma_rd_addr_i              (cmd_addr),
    .dma_rd_fifo_full_o         (fifo_full),
    .dma_rd_space_i             (space),
    .dma_rd_data_o              (out_data),
    .dma_rd_data_valid_o        (out_valid),
    .dma_rd_cmd_done_o          (cmd_done),
    .dma_rd_busy_o              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Written only by the main sequence
  int n_tests = 0;
  int n_fail  = 0;
  int skip    = 0;
  int resp_limit = 1 << 30;

  // Written only by the monitor
  int          accepted = 0;
  int          nb = 0;
  int          done_cnt = 0;
  int          beats_out = 0;
  int          beats_at_done = 0;
  int          lat_err = 0;
  logic [31:0] blog_addr [256];
  int          blog_cnt  [256];

  // Written only by the responder
  int returned = 0;

  // Monitor: everything observed here was stable since the preceding negedge.
  initial begin : monitor
    logic              prev_dv;
    logic [DATA_W-1:0] prev_data;
    prev_dv   = 1'b0;
    prev_data = '0;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        prev_dv = 1'b0;
      end else begin
        if (rd_read && !rd_wait_req) begin
          if (nb < 256) begin
            blog_addr[nb] = rd_addr;
            blog_cnt[nb]  = int'(rd_bcount);
          end
          nb++;
          accepted += int'(rd_bcount);
        end
        if (cmd_done) begin
          done_cnt++;
          beats_at_done = beats_out;
        end
        if (out_valid !== prev_dv) lat_err++;
        else if (prev_dv && (out_data !== prev_data)) lat_err++;
        if (out_valid) beats_out++;
        prev_dv   = rd_dv;
        prev_data = rd_data;
      end
    end
  end

  // AVMM slave model: one beat per cycle for every accepted beat not yet returned.
  initial begin : responder
    rd_dv   = 1'b0;
    rd_data = '0;
    forever begin
      @(negedge clk);
      if (reset_n && (accepted - returned - skip) > 0 && returned < resp_limit) begin
        rd_dv   = 1'b1;
        rd_data = {(DATA_W/32){32'(returned) ^ 32'hA5A5_0000}};
        returned++;
      end else begin
        rd_dv = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input int bytes, input logic [31:0] addr);
    @(negedge clk);
    cmd_req   = 1'b1;
    cmd_bytes = LEN_W'(bytes);
    cmd_addr  = addr;
    @(negedge clk);
    cmd_req   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(done_cnt >= target), 1);
  endtask

  task automatic wait_read(input string tag, input int budget);
    int k;
    k = 0;
    while (!rd_read && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(rd_read), 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int d0, b0, r0, k;
    logic [31:0] a0;
    logic [BCNT_W-1:0] c0;
    logic stable;

    reset_n = 1'b0; cmd_req = 1'b0; cmd_bytes = '0; cmd_addr = '0;
    rd_wait_req = 1'b0; space = SPACE_W'(64);
    repeat (3) @(negedge clk);
    check("rst_read",  64'(rd_read), 0);
    check("rst_addr",  64'(rd_addr), 0);
    check("rst_full",  64'(fifo_full), 0);
    check("rst_busy",  64'(busy), 0);
    check("rst_done",  64'(cmd_done), 0);
    check("rst_valid", 64'(out_valid), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single burst
    d0 = done_cnt; b0 = nb; r0 = beats_out;
    send(64, 32'h1000);
    wait_done("t1_done", d0 + 1, 100);
    check("t1_busy_low", 64'(busy), 0);
    repeat (5) @(negedge clk);
    check("t1_nbursts", 64'(nb - b0), 1);
    check("t1_addr",    64'(blog_addr[b0]), 32'h1000);
    check("t1_bcount",  64'(blog_cnt[b0]), 2);
    check("t1_beats",   64'(beats_out - r0), 2);
    check("t1_one_done", 64'(done_cnt - d0), 1);

    // Rounding / alignment, then zero-length command
    d0 = done_cnt; b0 = nb;
    send(33, 32'h101F);
    wait_done("t2_done", d0 + 1, 100);
    check("t2_addr",   64'(blog_addr[b0]), 32'h1000);
    check("t2_bcount", 64'(blog_cnt[b0]), 2);
    repeat (3) @(negedge clk);
    d0 = done_cnt; b0 = nb;
    send(0, 32'h3000);
    wait_done("t2_zero_done", d0 + 1, 50);
    repeat (5) @(negedge clk);
    check("t2_zero_noread", 64'(nb - b0), 0);
    check("t2_zero_one_done", 64'(done_cnt - d0), 1);

    // Splitting into two max bursts
    d0 = done_cnt; b0 = nb; r0 = beats_out;
    send(1024, 32'h2000);
    wait_done("t3_done", d0 + 1, 200);
    check("t3_nbursts", 64'(nb - b0), 2);
    check("t3_addr0",   64'(blog_addr[b0]), 32'h2000);
    check("t3_cnt0",    64'(blog_cnt[b0]), 16);
    check("t3_addr1",   64'(blog_addr[b0+1]), 32'h2200);
    check("t3_cnt1",    64'(blog_cnt[b0+1]), 16);
    check("t3_beats_at_done", 64'(beats_at_done - r0), 32);
    repeat (3) @(negedge clk);

    // Waitrequest hold
    d0 = done_cnt; b0 = nb; r0 = beats_out;
    rd_wait_req = 1'b1;
    send(64, 32'h4000);
    wait_read("t4_read_up", 50);
    a0 = rd_addr; c0 = rd_bcount; stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!rd_read || rd_addr != a0 || rd_bcount != c0) stable = 1'b0;
    end
    check("t4_stable", 64'(stable), 1);
    check("t4_addr",   64'(a0), 32'h4000);
    check("t4_bcount", 64'(c0), 2);
    check("t4_none_accepted", 64'(nb - b0), 0);
    rd_wait_req = 1'b0;
    wait_done("t4_done", d0 + 1, 100);
    check("t4_nbursts", 64'(nb - b0), 1);
    check("t4_beats",   64'(beats_out - r0), 2);
    repeat (3) @(negedge clk);

    // Downstream credit
    d0 = done_cnt; b0 = nb;
    space = SPACE_W'(8);
    send(512, 32'h5000);
    repeat (20) @(negedge clk);
    check("t5_blocked8", 64'(rd_read), 0);
    space = SPACE_W'(15);
    repeat (10) @(negedge clk);
    check("t5_blocked15", 64'(rd_read), 0);
    check("t5_no_burst", 64'(nb - b0), 0);
    space = SPACE_W'(16);
    wait_done("t5_done", d0 + 1, 100);
    check("t5_nbursts", 64'(nb - b0), 1);
    check("t5_bcount",  64'(blog_cnt[b0]), 16);
    space = SPACE_W'(64);
    repeat (3) @(negedge clk);

    // Command FIFO full / overflow drop
    d0 = done_cnt; b0 = nb;
    space = SPACE_W'(0);
    send(32, 32'h6000);
    repeat (5) @(negedge clk);
    check("t6_stuck", 64'(rd_read), 0);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i == 31) check("t6_not_full_31", 64'(fifo_full), 0);
      cmd_req = 1'b1; cmd_bytes = '0; cmd_addr = 32'(i) << 8;
    end
    @(negedge clk);
    check("t6_full", 64'(fifo_full), 1);
    cmd_addr = 32'h9999;   // 33rd write, must be dropped
    @(negedge clk);
    cmd_req = 1'b0;
    check("t6_still_full", 64'(fifo_full), 1);
    space = SPACE_W'(64);
    wait_done("t6_all_done", d0 + 33, 600);
    repeat (20) @(negedge clk);
    check("t6_done_count", 64'(done_cnt - d0), 33);
    check("t6_nbursts",    64'(nb - b0), 1);
    check("t6_full_clear", 64'(fifo_full), 0);

    // 4 KB boundary
    d0 = done_cnt; b0 = nb;
    send(256, 32'h0F80);
    wait_done("t7_done", d0 + 1, 100);
    check("t7_addr0", 64'(blog_addr[b0]), 32'h0F80);
`ifdef DMA_RD_4K_BOUNDARY_EN
    check("t7_nbursts", 64'(nb - b0), 2);
    check("t7_cnt0",    64'(blog_cnt[b0]), 4);
    check("t7_addr1",   64'(blog_addr[b0+1]), 32'h1000);
    check("t7_cnt1",    64'(blog_cnt[b0+1]), 4);
`else
    check("t7_nbursts", 64'(nb - b0), 1);
    check("t7_cnt0",    64'(blog_cnt[b0]), 8);
`endif
    repeat (3) @(negedge clk);

    // Async reset mid-ISSUE with 5 beats outstanding
    d0 = done_cnt; b0 = nb;
    space = SPACE_W'(21);
    resp_limit = returned;
    send(1024, 32'h7000);
    k = 0;
    while (nb == b0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t8_first_accept", 64'(nb - b0), 1);
    rd_wait_req = 1'b1;
    resp_limit = returned + 11;
    wait_read("t8_second_issue", 100);
    check("t8_second_addr", 64'(rd_addr), 32'h7200);
    #2;
    reset_n = 1'b0;
    #1;
    check("t8_read_0",   64'(rd_read), 0);
    check("t8_addr_0",   64'(rd_addr), 0);
    check("t8_bcount_0", 64'(rd_bcount), 0);
    check("t8_busy_0",   64'(busy), 0);
    check("t8_valid_0",  64'(out_valid), 0);
    skip = accepted - returned;
    resp_limit = 1 << 30;
    rd_wait_req = 1'b0;
    space = SPACE_W'(64);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("t8_no_done", 64'(done_cnt - d0), 0);
    check("t8_idle_busy", 64'(busy), 0);
    d0 = done_cnt; b0 = nb;
    send(64, 32'h8000);
    wait_done("t8_new_done", d0 + 1, 100);
    check("t8_new_addr", 64'(blog_addr[b0]), 32'h8000);
    check("t8_new_bcount", 64'(blog_cnt[b0]), 2);

    repeat (3) @(negedge clk);
    check("data_latency", 64'(lat_err), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
